// File: rtl/conv_load_tx.sv
// conv_load_tx: streams a preloaded operand buffer into the convolution
// controller's three load channels, in the order input, kernel, index.
//
// Ports:
//   clk, rstn                 clock (rising edge), async active-low reset
//   start                     begin a load sequence (sampled only in IDLE)
//   busy, done                sequence in progress / one-cycle completion pulse
//   rden, rdaddr, rddata      operand buffer read port (data 1 cycle after rden)
//   procin/prockrnl/procindx  channel-active flags
//   invalid/inlast/inready    input channel handshake
//   krnlvalid/krnlast/krnlready  kernel channel handshake
//   indxvalid/indxlast/indxready index channel handshake
//   txdata                    beat data for whichever channel is active
module conv_load_tx #(
    parameter int DW       = 16,
    parameter int AW       = 10,
    parameter int INPT_LEN = 9,
    parameter int KRNL_LEN = 513,
    parameter int INDX_LEN = 257
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic          rden,
    output logic [AW-1:0] rdaddr,
    input  logic [DW-1:0] rddata,
    output logic          procin,
    output logic          prockrnl,
    output logic          procindx,
    output logic          invalid,
    output logic          inlast,
    input  logic          inready,
    output logic          krnlvalid,
    output logic          krnlast,
    input  logic          krnlready,
    output logic          indxvalid,
    output logic          indxlast,
    input  logic          indxready,
    output logic [DW-1:0] txdata
);

    localparam int MAXLEN = (INPT_LEN > KRNL_LEN) ?
                            ((INPT_LEN > INDX_LEN) ? INPT_LEN : INDX_LEN) :
                            ((KRNL_LEN > INDX_LEN) ? KRNL_LEN : INDX_LEN);
    localparam int CW = $clog2(MAXLEN + 1);

    typedef enum logic [1:0] {IDLE, INPT, KRNL, INDX} state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   rd_cnt_q, rd_cnt_d;   // reads issued in current channel
    logic [CW-1:0]   beat_q, beat_d;       // beats transferred in current channel
    logic [AW-1:0]   addr_q, addr_d;
    logic            rdv_q;                // read issued last cycle, data on rddata now
    logic [DW-1:0]   out_q, out_d, sk_q, sk_d;
    logic            ov_q, ov_d, sv_q, sv_d;
    logic            done_q, done_d;

    logic [CW-1:0]   len;
    logic            ready, pop, last_beat;
    logic [1:0]      fill;

    always_comb begin
        len   = '0;
        ready = 1'b0;
        case (state_q)
            INPT:    begin len = CW'(INPT_LEN); ready = inready;   end
            KRNL:    begin len = CW'(KRNL_LEN); ready = krnlready; end
            INDX:    begin len = CW'(INDX_LEN); ready = indxready; end
            default: ;
        endcase
    end

    assign pop       = ov_q && ready;
    assign last_beat = (beat_q == len - CW'(1));
    // Entries held after this edge, counting the beat leaving now, so a
    // steady ready stream still gets one read per cycle with only 2 entries.
    assign fill      = 2'(ov_q) + 2'(sv_q) + 2'(rdv_q) - 2'(pop);
    assign rden      = (state_q != IDLE) && (rd_cnt_q < len) && (fill < 2'd2);

    always_comb begin
        state_d  = state_q;
        rd_cnt_d = rd_cnt_q;
        beat_d   = beat_q;
        addr_d   = addr_q;
        done_d   = 1'b0;
        out_d    = out_q;
        sk_d     = sk_q;
        ov_d     = ov_q;
        sv_d     = sv_q;

        // Output register refills from the skid first, then from the read
        // port; the skid only fills while the output is stalled or full.
        if (!ov_q || pop) begin
            if (sv_q) begin
                out_d = sk_q;
                ov_d  = 1'b1;
                sv_d  = rdv_q;
                if (rdv_q) sk_d = rddata;
            end else begin
                ov_d = rdv_q;
                sv_d = 1'b0;
                if (rdv_q) out_d = rddata;
            end
        end else if (rdv_q) begin
            sv_d = 1'b1;
            sk_d = rddata;
        end

        if (rden) begin
            rd_cnt_d = rd_cnt_q + CW'(1);
            addr_d   = addr_q + AW'(1);
        end
        if (pop) beat_d = beat_q + CW'(1);

        case (state_q)
            IDLE: if (start) begin
                state_d  = INPT;
                addr_d   = '0;
                rd_cnt_d = '0;
                beat_d   = '0;
            end
            default: if (pop && last_beat) begin
                rd_cnt_d = '0;
                beat_d   = '0;
                case (state_q)
                    INPT:    state_d = KRNL;
                    KRNL:    state_d = INDX;
                    default: begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                        addr_d  = '0;
                    end
                endcase
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= IDLE;
            rd_cnt_q <= '0;
            beat_q   <= '0;
            addr_q   <= '0;
            rdv_q    <= 1'b0;
            out_q    <= '0;
            sk_q     <= '0;
            ov_q     <= 1'b0;
            sv_q     <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            rd_cnt_q <= rd_cnt_d;
            beat_q   <= beat_d;
            addr_q   <= addr_d;
            rdv_q    <= rden;
            out_q    <= out_d;
            sk_q     <= sk_d;
            ov_q     <= ov_d;
            sv_q     <= sv_d;
            done_q   <= done_d;
        end
    end

    assign busy      = (state_q != IDLE);
    assign done      = done_q;
    assign rdaddr    = addr_q;
    assign txdata    = out_q;
    assign procin    = (state_q == INPT);
    assign prockrnl  = (state_q == KRNL);
    assign procindx  = (state_q == INDX);
    assign invalid   = ov_q && procin;
    assign krnlvalid = ov_q && prockrnl;
    assign indxvalid = ov_q && procindx;
    assign inlast    = invalid   && last_beat;
    assign krnlast   = krnlvalid && last_beat;
    assign indxlast  = indxvalid && last_beat;

endmodule
